// File: rtl/lsf_hit_merge_buffer.sv
// lsf_hit_merge_buffer: N_CH first-word-fall-through hit FIFOs merged round-robin
// into a single registered re/empty read port, plus one FWFT ROI FIFO, with
// freeze, saturating drop accounting and event-boundary arbiter reset.
module lsf_hit_merge_buffer #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned HIT_W     = 32,
  parameter int unsigned ROI_W     = 32,
  parameter int unsigned HIT_DEPTH = 32,
  parameter int unsigned ROI_DEPTH = 8,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH*HIT_W-1:0] mdt_hit,
  input  logic [N_CH-1:0]       mdt_hit_we,
  output logic [N_CH-1:0]       mdt_hit_af,
  input  logic [ROI_W-1:0]      roi,
  input  logic                  roi_we,
  output logic                  roi_af,
  output logic [HIT_W-1:0]      lsf_mdt_hit,
  output logic [CH_W-1:0]       lsf_mdt_hit_ch,
  input  logic                  lsf_mdt_hit_re,
  output logic                  lsf_mdt_hit_empty,
  output logic [ROI_W-1:0]      lsf_roi,
  input  logic                  lsf_roi_re,
  output logic                  lsf_roi_empty,
  input  logic                  freeze,
  input  logic                  i_eof,
  output logic [CNT_W-1:0]      hit_drop_count,
  output logic [CNT_W-1:0]      roi_drop_count
);

  localparam int unsigned HAW       = $clog2(HIT_DEPTH);
  localparam int unsigned HCW       = HAW + 1;
  localparam int unsigned RAW       = $clog2(ROI_DEPTH);
  localparam int unsigned RCW       = RAW + 1;
  localparam int unsigned HIT_AF_TH = HIT_DEPTH - AF_MARGIN;
  localparam int unsigned ROI_AF_TH = ROI_DEPTH - AF_MARGIN;

  // Hit FIFO storage and bookkeeping
  logic [HIT_W-1:0]             hit_mem_q [N_CH][HIT_DEPTH];
  logic [N_CH-1:0][HAW-1:0]     hit_wp_q, hit_wp_d, hit_rp_q, hit_rp_d;
  logic [N_CH-1:0][HCW-1:0]     hit_cnt_q, hit_cnt_d;
  logic [N_CH-1:0][HIT_W-1:0]   hit_head;
  logic [N_CH-1:0]              hit_full, hit_nonempty, hit_wr, hit_pop, hit_drop;
  logic [N_CH-1:0]              hit_af_q, hit_af_d;
  logic [CNT_W-1:0]             hit_drop_cnt_q, hit_drop_cnt_d;
  logic [3:0]                   hit_drop_n;
  logic [CNT_W+3:0]             hit_drop_sum;

  // Merge register and arbiter
  logic [HIT_W-1:0]             head_q, head_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic                         valid_q, valid_d;
  logic [CH_W-1:0]              ptr_q, ptr_d;
  logic                         merge_pop, merge_refill, cand_found;
  logic [CH_W-1:0]              cand_ch, scan_ch;
  logic [CH_W:0]                scan_idx;

  // ROI FIFO
  logic [ROI_W-1:0]             roi_mem_q [ROI_DEPTH];
  logic [RAW-1:0]               roi_wp_q, roi_wp_d, roi_rp_q, roi_rp_d;
  logic [RCW-1:0]               roi_cnt_q, roi_cnt_d;
  logic                         roi_full, roi_fifo_empty, roi_wr, roi_pop, roi_drop;
  logic                         roi_af_q, roi_af_d;
  logic [CNT_W-1:0]             roi_drop_cnt_q, roi_drop_cnt_d;

  // Per-channel status derived purely from registered state
  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      hit_full[c]     = (hit_cnt_q[c] == HCW'(HIT_DEPTH));
      hit_nonempty[c] = (hit_cnt_q[c] != '0);
      hit_head[c]     = hit_mem_q[c][hit_rp_q[c]];
    end
  end

  // Round-robin refill of the merge register starting at ptr
  always_comb begin
    hit_pop      = '0;
    cand_found   = 1'b0;
    cand_ch      = '0;
    scan_idx     = '0;
    scan_ch      = '0;
    head_d       = head_q;
    ch_d         = ch_q;
    valid_d      = valid_q;
    ptr_d        = ptr_q;
    merge_pop    = lsf_mdt_hit_re & valid_q & ~freeze;
    merge_refill = (~valid_q | merge_pop) & ~freeze;
    for (int k = 0; k < int'(N_CH); k++) begin
      scan_idx = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (scan_idx >= (CH_W+1)'(N_CH)) scan_idx = scan_idx - (CH_W+1)'(N_CH);
      scan_ch = scan_idx[CH_W-1:0];
      if (!cand_found && hit_nonempty[scan_ch]) begin
        cand_found = 1'b1;
        cand_ch    = scan_ch;
      end
    end
    if (merge_refill) begin
      if (cand_found) begin
        hit_pop[cand_ch] = 1'b1;
        head_d           = hit_head[cand_ch];
        ch_d             = cand_ch;
        valid_d          = 1'b1;
        ptr_d            = (cand_ch == CH_W'(N_CH - 1)) ? '0 : cand_ch + CH_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
    if (i_eof) ptr_d = '0;
  end

  // Hit FIFO write/pop accounting; a write to a full FIFO lands only if it pops
  always_comb begin
    hit_drop_n = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      hit_wr[c]    = mdt_hit_we[c] & (~hit_full[c] | hit_pop[c]);
      hit_drop[c]  = mdt_hit_we[c] & hit_full[c] & ~hit_pop[c];
      hit_wp_d[c]  = hit_wr[c]  ? hit_wp_q[c] + HAW'(1) : hit_wp_q[c];
      hit_rp_d[c]  = hit_pop[c] ? hit_rp_q[c] + HAW'(1) : hit_rp_q[c];
      hit_cnt_d[c] = hit_cnt_q[c] + HCW'(hit_wr[c]) - HCW'(hit_pop[c]);
      hit_af_d[c]  = (hit_cnt_d[c] >= HCW'(HIT_AF_TH));
      hit_drop_n   = hit_drop_n + 4'(hit_drop[c]);
    end
    hit_drop_sum   = (CNT_W+4)'(hit_drop_cnt_q) + (CNT_W+4)'(hit_drop_n);
    hit_drop_cnt_d = (|hit_drop_sum[CNT_W+3:CNT_W]) ? '1 : hit_drop_sum[CNT_W-1:0];
  end

  // ROI FIFO accounting with the same full/pop rules
  always_comb begin
    roi_full       = (roi_cnt_q == RCW'(ROI_DEPTH));
    roi_fifo_empty = (roi_cnt_q == '0);
    roi_pop        = lsf_roi_re & ~roi_fifo_empty & ~freeze;
    roi_wr         = roi_we & (~roi_full | roi_pop);
    roi_drop       = roi_we & roi_full & ~roi_pop;
    roi_wp_d       = roi_wr  ? roi_wp_q + RAW'(1) : roi_wp_q;
    roi_rp_d       = roi_pop ? roi_rp_q + RAW'(1) : roi_rp_q;
    roi_cnt_d      = roi_cnt_q + RCW'(roi_wr) - RCW'(roi_pop);
    roi_af_d       = (roi_cnt_d >= RCW'(ROI_AF_TH));
    roi_drop_cnt_d = (roi_drop && (roi_drop_cnt_q != '1)) ? roi_drop_cnt_q + CNT_W'(1)
                                                          : roi_drop_cnt_q;
  end

  // Control state; reset empties every FIFO and the merge register at once
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_wp_q       <= '0;
      hit_rp_q       <= '0;
      hit_cnt_q      <= '0;
      hit_af_q       <= '0;
      hit_drop_cnt_q <= '0;
      head_q         <= '0;
      ch_q           <= '0;
      valid_q        <= 1'b0;
      ptr_q          <= '0;
      roi_wp_q       <= '0;
      roi_rp_q       <= '0;
      roi_cnt_q      <= '0;
      roi_af_q       <= 1'b0;
      roi_drop_cnt_q <= '0;
    end else begin
      hit_wp_q       <= hit_wp_d;
      hit_rp_q       <= hit_rp_d;
      hit_cnt_q      <= hit_cnt_d;
      hit_af_q       <= hit_af_d;
      hit_drop_cnt_q <= hit_drop_cnt_d;
      head_q         <= head_d;
      ch_q           <= ch_d;
      valid_q        <= valid_d;
      ptr_q          <= ptr_d;
      roi_wp_q       <= roi_wp_d;
      roi_rp_q       <= roi_rp_d;
      roi_cnt_q      <= roi_cnt_d;
      roi_af_q       <= roi_af_d;
      roi_drop_cnt_q <= roi_drop_cnt_d;
    end
  end

  // Storage arrays; stale contents are harmless because counts gate reads
  always_ff @(posedge clock) begin
    for (int c = 0; c < int'(N_CH); c++) begin
      if (hit_wr[c]) hit_mem_q[c][hit_wp_q[c]] <= mdt_hit[c*HIT_W +: HIT_W];
    end
    if (roi_wr) roi_mem_q[roi_wp_q] <= roi;
  end

  assign mdt_hit_af        = hit_af_q;
  assign roi_af            = roi_af_q;
  assign lsf_mdt_hit       = head_q;
  assign lsf_mdt_hit_ch    = ch_q;
  assign lsf_mdt_hit_empty = ~valid_q | freeze;
  assign lsf_roi           = roi_fifo_empty ? '0 : roi_mem_q[roi_rp_q];
  assign lsf_roi_empty     = roi_fifo_empty | freeze;
  assign hit_drop_count    = hit_drop_cnt_q;
  assign roi_drop_count    = roi_drop_cnt_q;

endmodule

// File: tb/tb_lsf_hit_merge_buffer.sv
// Directed bench for lsf_hit_merge_buffer with hand-computed expectations.
module tb_lsf_hit_merge_buffer;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned HIT_W = 16;
  localparam int unsigned ROI_W = 12;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CH_W  = 2;

  logic                  clock;
  logic                  reset;
  logic [N_CH*HIT_W-1:0] mdt_hit;
  logic [N_CH-1:0]       mdt_hit_we;
  logic [N_CH-1:0]       mdt_hit_af;
  logic [ROI_W-1:0]      roi;
  logic                  roi_we;
  logic                  roi_af;
  logic [HIT_W-1:0]      lsf_mdt_hit;
  logic [CH_W-1:0]       lsf_mdt_hit_ch;
  logic                  lsf_mdt_hit_re;
  logic                  lsf_mdt_hit_empty;
  logic [ROI_W-1:0]      lsf_roi;
  logic                  lsf_roi_re;
  logic                  lsf_roi_empty;
  logic                  freeze;
  logic                  i_eof;
  logic [CNT_W-1:0]      hit_drop_count;
  logic [CNT_W-1:0]      roi_drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  lsf_hit_merge_buffer #(
    .N_CH(N_CH), .HIT_W(HIT_W), .ROI_W(ROI_W), .HIT_DEPTH(32),
    .ROI_DEPTH(8), .AF_MARGIN(4), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .mdt_hit(mdt_hit), .mdt_hit_we(mdt_hit_we), .mdt_hit_af(mdt_hit_af),
    .roi(roi), .roi_we(roi_we), .roi_af(roi_af),
    .lsf_mdt_hit(lsf_mdt_hit), .lsf_mdt_hit_ch(lsf_mdt_hit_ch),
    .lsf_mdt_hit_re(lsf_mdt_hit_re), .lsf_mdt_hit_empty(lsf_mdt_hit_empty),
    .lsf_roi(lsf_roi), .lsf_roi_re(lsf_roi_re), .lsf_roi_empty(lsf_roi_empty),
    .freeze(freeze), .i_eof(i_eof),
    .hit_drop_count(hit_drop_count), .roi_drop_count(roi_drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Single comparison point for every check
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic put_hit(input int c, input logic [HIT_W-1:0] v);
    mdt_hit[c*HIT_W +: HIT_W] = v;
    mdt_hit_we[c] = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mdt_hit = '0; mdt_hit_we = '0; roi = '0; roi_we = 1'b0;
    lsf_mdt_hit_re = 1'b0; lsf_roi_re = 1'b0; freeze = 1'b0; i_eof = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_empty",    32'(lsf_mdt_hit_empty), 32'd1);
    chk("rst_roi_empty", 32'(lsf_roi_empty),    32'd1);
    chk("rst_af",       32'(mdt_hit_af),        32'd0);
    chk("rst_roi_af",   32'(roi_af),            32'd0);
    chk("rst_hit",      32'(lsf_mdt_hit),       32'd0);
    chk("rst_ch",       32'(lsf_mdt_hit_ch),    32'd0);
    chk("rst_roi",      32'(lsf_roi),           32'd0);
    chk("rst_hdrop",    32'(hit_drop_count),    32'd0);
    chk("rst_rdrop",    32'(roi_drop_count),    32'd0);

    // Single hit on ch2: visible two cycles after the write
    put_hit(2, 16'h005A); step(); mdt_hit_we = '0;
    chk("t1_empty_T1", 32'(lsf_mdt_hit_empty), 32'd1);
    step();
    chk("t1_empty_T2", 32'(lsf_mdt_hit_empty), 32'd0);
    chk("t1_hit",      32'(lsf_mdt_hit),       32'h5A);
    chk("t1_ch",       32'(lsf_mdt_hit_ch),    32'd2);
    lsf_mdt_hit_re = 1'b1; step(); lsf_mdt_hit_re = 1'b0;
    chk("t1_popped",   32'(lsf_mdt_hit_empty), 32'd1);

    // One hit per channel with eof clearing the pointer: served ch0..ch3
    for (int c = 0; c < 4; c++) put_hit(c, 16'(16'h0100 + c));
    i_eof = 1'b1; step(); i_eof = 1'b0; mdt_hit_we = '0;
    lsf_mdt_hit_re = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_rr_ch",  32'(lsf_mdt_hit_ch), 32'(k));
      chk("t2_rr_hit", 32'(lsf_mdt_hit),    32'(16'h0100 + k));
    end
    step();
    chk("t2_drained", 32'(lsf_mdt_hit_empty), 32'd1);
    put_hit(1, 16'h0201); put_hit(3, 16'h0203); step(); mdt_hit_we = '0;
    step();
    chk("t2_sparse_ch0", 32'(lsf_mdt_hit_ch), 32'd1);
    chk("t2_sparse_hit0", 32'(lsf_mdt_hit),   32'h0201);
    step();
    chk("t2_sparse_ch1", 32'(lsf_mdt_hit_ch), 32'd3);
    chk("t2_sparse_hit1", 32'(lsf_mdt_hit),   32'h0203);
    step();
    chk("t2_sparse_empty", 32'(lsf_mdt_hit_empty), 32'd1);
    lsf_mdt_hit_re = 1'b0;

    // Fill ch0 under freeze: af at 28, three drops, data intact
    freeze = 1'b1;
    for (int i = 0; i < 35; i++) begin
      put_hit(0, 16'(16'h0300 + i)); step();
      if (i == 26) chk("t3_af_27", 32'(mdt_hit_af[0]), 32'd0);
      if (i == 27) chk("t3_af_28", 32'(mdt_hit_af[0]), 32'd1);
    end
    mdt_hit_we = '0;
    chk("t3_hdrop",        32'(hit_drop_count),    32'd3);
    chk("t3_frozen_empty", 32'(lsf_mdt_hit_empty), 32'd1);
    freeze = 1'b0; lsf_mdt_hit_re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("t3_order", 32'(lsf_mdt_hit), 32'(16'h0300 + i));
    end
    step();
    chk("t3_empty", 32'(lsf_mdt_hit_empty), 32'd1);
    chk("t3_af_clr", 32'(mdt_hit_af[0]),    32'd0);
    lsf_mdt_hit_re = 1'b0;

    // Freeze holds five buffered hits against re pulses
    for (int i = 0; i < 5; i++) begin
      put_hit(1, 16'(16'h0400 + i)); step();
    end
    mdt_hit_we = '0; step();
    freeze = 1'b1; lsf_mdt_hit_re = 1'b1; #1;
    chk("t4_frz_empty", 32'(lsf_mdt_hit_empty), 32'd1);
    step(); step();
    chk("t4_frz_empty2", 32'(lsf_mdt_hit_empty), 32'd1);
    chk("t4_frz_head",   32'(lsf_mdt_hit),       32'h0400);
    freeze = 1'b0; #1;
    chk("t4_unfrz_empty", 32'(lsf_mdt_hit_empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_data", 32'(lsf_mdt_hit), 32'(16'h0400 + i));
      step();
    end
    chk("t4_empty", 32'(lsf_mdt_hit_empty), 32'd1);
    lsf_mdt_hit_re = 1'b0;

    // eof after serving ch1: ch0 must win over ch2
    put_hit(1, 16'h0501); step(); mdt_hit_we = '0; step();
    chk("t5_first_ch", 32'(lsf_mdt_hit_ch), 32'd1);
    put_hit(0, 16'h0500); put_hit(2, 16'h0502); step(); mdt_hit_we = '0;
    i_eof = 1'b1; step(); i_eof = 1'b0;
    lsf_mdt_hit_re = 1'b1; step();
    chk("t5_eof_ch",  32'(lsf_mdt_hit_ch), 32'd0);
    chk("t5_eof_hit", 32'(lsf_mdt_hit),    32'h0500);
    step();
    chk("t5_next_ch", 32'(lsf_mdt_hit_ch), 32'd2);
    step();
    chk("t5_empty",   32'(lsf_mdt_hit_empty), 32'd1);
    lsf_mdt_hit_re = 1'b0;

    // ROI FIFO: one-cycle latency, drops, freeze, write+pop on full
    roi = 12'h0A1; roi_we = 1'b1; step(); roi_we = 1'b0;
    chk("t6_roi_empty", 32'(lsf_roi_empty), 32'd0);
    chk("t6_roi_head",  32'(lsf_roi),       32'h0A1);
    for (int i = 2; i <= 10; i++) begin
      roi = 12'(12'h0A0 + i); roi_we = 1'b1; step();
    end
    roi_we = 1'b0;
    chk("t6_rdrop",  32'(roi_drop_count), 32'd2);
    chk("t6_roi_af", 32'(roi_af),         32'd1);
    freeze = 1'b1; lsf_roi_re = 1'b1; #1;
    chk("t6_frz_empty", 32'(lsf_roi_empty), 32'd1);
    step();
    freeze = 1'b0; lsf_roi_re = 1'b0; #1;
    chk("t6_frz_head", 32'(lsf_roi), 32'h0A1);
    roi = 12'h0BB; roi_we = 1'b1; lsf_roi_re = 1'b1; step(); roi_we = 1'b0;
    chk("t6_wrpop_drop", 32'(roi_drop_count), 32'd2);
    chk("t6_wrpop_head", 32'(lsf_roi),        32'h0A2);
    for (int i = 2; i <= 8; i++) begin
      chk("t6_order", 32'(lsf_roi), 32'(12'h0A0 + i));
      step();
    end
    chk("t6_last", 32'(lsf_roi), 32'h0BB);
    step();
    chk("t6_empty",    32'(lsf_roi_empty), 32'd1);
    chk("t6_af_clr",   32'(roi_af),        32'd0);
    lsf_roi_re = 1'b0;

    // Reset with FIFOs half full discards everything in one cycle
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 4; c++) put_hit(c, 16'(16'h0600 + i));
      if (i < 4) begin roi = 12'(12'h0C0 + i); roi_we = 1'b1; end
      else roi_we = 1'b0;
      step();
    end
    mdt_hit_we = '0; roi_we = 1'b0;
    chk("t7_pre_roi_af", 32'(roi_af),         32'd1);
    chk("t7_pre_hdrop",  32'(hit_drop_count), 32'd3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t7_empty",     32'(lsf_mdt_hit_empty), 32'd1);
    chk("t7_roi_empty", 32'(lsf_roi_empty),     32'd1);
    chk("t7_af",        32'(mdt_hit_af),        32'd0);
    chk("t7_roi_af",    32'(roi_af),            32'd0);
    chk("t7_hdrop",     32'(hit_drop_count),    32'd0);
    chk("t7_rdrop",     32'(roi_drop_count),    32'd0);
    chk("t7_hit",       32'(lsf_mdt_hit),       32'd0);
    chk("t7_roi",       32'(lsf_roi),           32'd0);
    put_hit(3, 16'h0777); step(); mdt_hit_we = '0;
    chk("t7_fresh_T1", 32'(lsf_mdt_hit_empty), 32'd1);
    step();
    chk("t7_fresh_empty", 32'(lsf_mdt_hit_empty), 32'd0);
    chk("t7_fresh_hit",   32'(lsf_mdt_hit),       32'h0777);
    chk("t7_fresh_ch",    32'(lsf_mdt_hit_ch),    32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
